// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources,
// with burst lock, start/busy handshake, inter-byte gap and acknowledge timeout.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int ACK_TIMEOUT = 20000,
  parameter int GAP_CYCLES  = 0,
  parameter int LOCK_IDLE   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_last,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_last,
  output logic       o_req1_ready,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic [1:0] o_grant,
  output logic       o_err,
  input  logic       i_err_clr
);

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LCK_W   = $clog2(LOCK_IDLE + 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_IDLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [LCK_W-1:0] lock_cnt_r, lock_cnt_s;
  logic             lock_r, lock_s;
  logic             last_r, last_s;
  logic             busy_meta_r, busy_sync_r;
  logic             tx_start_r, tx_start_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             ready0_r, ready0_s;
  logic             ready1_r, ready1_s;
  logic [1:0]       grant_r, grant_s;
  logic             err_r, err_s;
  logic             err_set_s;
  logic             pick_vld_s;
  logic             pick_s;

  // Register bank, including the two-flop synchroniser for the slow-domain busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      lock_cnt_r  <= '0;
      lock_r      <= 1'b0;
      last_r      <= 1'b1;
      busy_meta_r <= 1'b0;
      busy_sync_r <= 1'b0;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      ready0_r    <= 1'b0;
      ready1_r    <= 1'b0;
      grant_r     <= 2'b00;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      lock_cnt_r  <= lock_cnt_s;
      lock_r      <= lock_s;
      last_r      <= last_s;
      busy_meta_r <= i_tx_busy;
      busy_sync_r <= busy_meta_r;
      tx_start_r  <= tx_start_s;
      tx_data_r   <= tx_data_s;
      ready0_r    <= ready0_s;
      ready1_r    <= ready1_s;
      grant_r     <= grant_s;
      err_r       <= err_s;
    end
  end

  // Arbitration and transmitter sequencing; last_r doubles as the round-robin pointer
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    lock_cnt_s = lock_cnt_r;
    lock_s     = lock_r;
    last_s     = last_r;
    tx_start_s = tx_start_r;
    tx_data_s  = tx_data_r;
    ready0_s   = 1'b0;
    ready1_s   = 1'b0;
    grant_s    = grant_r;
    err_set_s  = 1'b0;
    pick_vld_s = 1'b0;
    pick_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lock_r) begin
          pick_s     = last_r;
          pick_vld_s = last_r ? i_req1_valid : i_req0_valid;
        end else if (i_req0_valid && i_req1_valid) begin
          pick_s     = ~last_r;
          pick_vld_s = 1'b1;
        end else if (i_req0_valid) begin
          pick_s     = 1'b0;
          pick_vld_s = 1'b1;
        end else if (i_req1_valid) begin
          pick_s     = 1'b1;
          pick_vld_s = 1'b1;
        end else begin
          pick_s     = 1'b0;
          pick_vld_s = 1'b0;
        end
        if (pick_vld_s) begin
          state_s    = ST_WAIT_ACK;
          cnt_s      = '0;
          lock_cnt_s = '0;
          tx_start_s = 1'b1;
          tx_data_s  = pick_s ? i_req1_data : i_req0_data;
          ready0_s   = ~pick_s;
          ready1_s   = pick_s;
          grant_s    = pick_s ? 2'b10 : 2'b01;
          last_s     = pick_s;
          lock_s     = ~(pick_s ? i_req1_last : i_req0_last);
        end else if (lock_r) begin
          if (lock_cnt_r == LOCK_LAST) begin
            lock_s     = 1'b0;
            grant_s    = 2'b00;
            lock_cnt_s = '0;
          end else begin
            lock_cnt_s = lock_cnt_r + LCK_W'(1);
          end
        end else begin
          lock_cnt_s = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (busy_sync_r) begin
          tx_start_s = 1'b0;
          state_s    = ST_WAIT_DONE;
          cnt_s      = '0;
        end else if (cnt_r == ACK_LAST) begin
          // Byte is dropped: the requester was already acknowledged
          tx_start_s = 1'b0;
          err_set_s  = 1'b1;
          lock_s     = 1'b0;
          grant_s    = 2'b00;
          state_s    = ST_IDLE;
          cnt_s      = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_sync_r) begin
          cnt_s = '0;
          if (GAP_CYCLES > 0) begin
            state_s = ST_GAP;
          end else begin
            state_s = ST_IDLE;
            grant_s = lock_r ? grant_r : 2'b00;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          grant_s = lock_r ? grant_r : 2'b00;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s    = ST_IDLE;
        cnt_s      = '0;
        tx_start_s = 1'b0;
      end
    endcase
  end

  // Sticky error: a new timeout wins over a coincident clear
  always_comb begin
    if (err_set_s) begin
      err_s = 1'b1;
    end else if (i_err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  assign o_req0_ready = ready0_r;
  assign o_req1_ready = ready1_r;
  assign o_tx_start   = tx_start_r;
  assign o_tx_data    = tx_data_r;
  assign o_grant      = grant_r;
  assign o_err        = err_r;

endmodule
